config_ring_counter: RTL and testbench

CONFIG_RING_COUNTER -- requirements
Module: config_ring_counter

---
 rtl/config_ring_counter.sv | 85 ++++++++
 tb/tb_config_ring_counter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/config_ring_counter.sv
// Configurable ring / Johnson counter with direction control, parallel load
// and optional recovery from illegal states.
module config_ring_counter #(
  parameter int WIDTH        = 4,
  parameter bit SELF_CORRECT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             legal,
  output logic             wrap,
  output logic             err
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_inc;
  logic [WIDTH-1:0] q_inv_inc;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] q_next;
  logic             ring_ok;
  logic             johnson_ok;
  logic             wrap_next;
  logic             err_next;

  // Legality of the current state under the currently selected mode.
  // A value of the form 0..01..1 has no bit in common with itself + 1;
  // the 1..10..0 form is the same test applied to the inverted value.
  always_comb begin
    q_inc      = q + ONE;
    q_inv_inc  = ~q + ONE;
    ring_ok    = (q != '0) && ((q & (q - ONE)) == '0);
    johnson_ok = ((q & q_inc) == '0) || ((~q & q_inv_inc) == '0);
    legal      = mode ? johnson_ok : ring_ok;
  end

  // One sequence step for the selected mode and direction.
  always_comb begin
    step_val = q;
    case ({mode, dir})
      2'b00:   step_val = {q[WIDTH-2:0], q[WIDTH-1]};
      2'b01:   step_val = {q[0], q[WIDTH-1:1]};
      2'b10:   step_val = {q[WIDTH-2:0], ~q[WIDTH-1]};
      2'b11:   step_val = {~q[0], q[WIDTH-1:1]};
      default: step_val = q;
    endcase
  end

  // Next-state selection: load wins over step, step over hold.
  always_comb begin
    q_next    = q;
    wrap_next = 1'b0;
    err_next  = 1'b0;
    if (load) begin
      q_next = load_val;
    end else if (en) begin
      if (SELF_CORRECT && !legal) begin
        q_next   = ONE;
        err_next = 1'b1;
      end else begin
        q_next    = step_val;
        wrap_next = (step_val == ONE);
      end
    end
  end

  // State and pulse registers; reset parks the counter on bit 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q    <= ONE;
      wrap <= 1'b0;
      err  <= 1'b0;
    end else begin
      q    <= q_next;
      wrap <= wrap_next;
      err  <= err_next;
    end
  end

endmodule

// File: tb/tb_config_ring_counter.sv
// Self-checking bench for config_ring_counter: three instances (4-bit with
// and without correction, 8-bit with correction) driven in lockstep and
// compared against an arithmetic reference model.
module tb_config_ring_counter;

  logic       clk = 1'b0;
  logic       reset, en, mode, dir, load;
  logic [3:0] load_val;
  logic [7:0] load_val8;
  logic [3:0] q, qn;
  logic [7:0] q8;
  logic       legal, wrap, err;
  logic       legal_n, wrap_n, err_n;
  logic       legal8, wrap8, err8;

  int checks = 0;
  int errors = 0;

  int m4 = 1, mnc = 1, m8 = 1;
  bit xw4, xe4, xwn, xen, xw8, xe8;

  always #5 clk = ~clk;

  config_ring_counter #(.WIDTH(4), .SELF_CORRECT(1'b1)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .dir(dir), .load(load),
    .load_val(load_val), .q(q), .legal(legal), .wrap(wrap), .err(err));

  config_ring_counter #(.WIDTH(4), .SELF_CORRECT(1'b0)) dut_nc (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .dir(dir), .load(load),
    .load_val(load_val), .q(qn), .legal(legal_n), .wrap(wrap_n), .err(err_n));

  config_ring_counter #(.WIDTH(8), .SELF_CORRECT(1'b1)) dut8 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .dir(dir), .load(load),
    .load_val(load_val8), .q(q8), .legal(legal8), .wrap(wrap8), .err(err8));

  // Reference: legal sets enumerated arithmetically.
  function automatic bit mlegal(int w, int qv, bit m);
    int full = 1 << w;
    int ones = 0;
    if (!m) begin
      for (int i = 0; i < w; i++) ones += (qv >> i) % 2;
      return ones == 1;
    end
    for (int k = 0; k <= w; k++) if (qv == (1 << k) - 1) return 1'b1;
    for (int k = 1; k < w; k++) if (qv == full - (1 << k)) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: next state as multiply/divide on the integer value.
  function automatic int mnext(int w, bit sc, int qv, bit l, int lv, bit e,
                               bit m, bit d, output bit wr, output bit er);
    int full = 1 << w;
    int top  = full / 2;
    int nx;
    wr = 1'b0;
    er = 1'b0;
    if (l) return lv % full;
    if (!e) return qv;
    if (sc && !mlegal(w, qv, m)) begin
      er = 1'b1;
      return 1;
    end
    if (!m) nx = d ? qv / 2 + (qv % 2) * top : (qv * 2) % full + qv / top;
    else    nx = d ? qv / 2 + (1 - qv % 2) * top : (qv * 2) % full + (1 - qv / top);
    wr = (nx == 1);
    return nx;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs();
    chk("q4", 32'(q), 32'(m4));
    chk("wrap4", 32'(wrap), 32'(xw4));
    chk("err4", 32'(err), 32'(xe4));
    chk("qnc", 32'(qn), 32'(mnc));
    chk("wrapnc", 32'(wrap_n), 32'(xwn));
    chk("errnc", 32'(err_n), 32'(xen));
    chk("q8", 32'(q8), 32'(m8));
    chk("wrap8", 32'(wrap8), 32'(xw8));
    chk("err8", 32'(err8), 32'(xe8));
  endtask

  task automatic check_legal();
    chk("legal4", 32'(legal), 32'(mlegal(4, m4, mode)));
    chk("legalnc", 32'(legal_n), 32'(mlegal(4, mnc, mode)));
    chk("legal8", 32'(legal8), 32'(mlegal(8, m8, mode)));
  endtask

  // Called at posedge+1: drive inputs, check legal, clock once, check state.
  task automatic cyc(input bit l, input int lv, input bit e, input bit m, input bit d);
    int n4, nn, n8;
    load = l; load_val = 4'(lv); load_val8 = 8'(lv); en = e; mode = m; dir = d;
    #1;
    check_legal();
    n4 = mnext(4, 1'b1, m4, l, lv, e, m, d, xw4, xe4);
    nn = mnext(4, 1'b0, mnc, l, lv, e, m, d, xwn, xen);
    n8 = mnext(8, 1'b1, m8, l, lv, e, m, d, xw8, xe8);
    xen = 1'b0;
    @(posedge clk);
    #1;
    m4 = n4; mnc = nn; m8 = n8;
    check_outs();
  endtask

  // Asynchronous reset asserted between edges, held across one edge.
  task automatic mid_reset();
    #2;
    reset = 1'b1;
    #1;
    m4 = 1; mnc = 1; m8 = 1;
    xw4 = 0; xe4 = 0; xwn = 0; xen = 0; xw8 = 0; xe8 = 0;
    check_outs();
    check_legal();
    @(posedge clk);
    #1;
    check_outs();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int wc;
    reset = 1'b0; en = 1'b0; mode = 1'b0; dir = 1'b0; load = 1'b0;
    load_val = '0; load_val8 = '0;
    @(posedge clk);
    #1;
    mid_reset();

    // Ring toward MSB.
    for (int i = 0; i < 4; i++) cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
    chk("r031_q", 32'(q), 32'h1);
    chk("r031_wrap", 32'(wrap), 32'h1);

    // Ring toward LSB.
    for (int i = 0; i < 4; i++) cyc(1'b0, 0, 1'b1, 1'b0, 1'b1);
    chk("r032_q", 32'(q), 32'h1);
    chk("r032_wrap", 32'(wrap), 32'h1);

    // Johnson from 0000.
    cyc(1'b1, 0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 0, 1'b1, 1'b1, 1'b0);
    chk("r033_q", 32'(q), 32'h0);
    chk("r033_legal", 32'(legal), 32'h1);

    // Illegal ring state, with and without correction.
    cyc(1'b1, 6, 1'b0, 1'b0, 1'b0);
    chk("r034_legal", 32'(legal), 32'h0);
    cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
    chk("r034_q", 32'(q), 32'h1);
    chk("r034_err", 32'(err), 32'h1);
    chk("r034_wrap", 32'(wrap), 32'h0);
    chk("r034_qnc", 32'(qn), 32'hc);
    chk("r034_errnc", 32'(err_n), 32'h0);

    // Async reset at 0100, then load+en together.
    cyc(1'b1, 4, 1'b0, 1'b0, 1'b0);
    chk("r035_pre", 32'(q), 32'h4);
    mid_reset();
    cyc(1'b1, 8, 1'b1, 1'b0, 1'b0);
    chk("r035_load", 32'(q), 32'h8);

    // 8-bit Johnson full period, then mode switch at 00000011.
    mid_reset();
    wc = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 0, 1'b1, 1'b1, 1'b0);
      wc += int'(wrap8);
    end
    chk("r036_q8", 32'(q8), 32'h1);
    chk("r036_wraps", 32'(wc), 32'h1);
    cyc(1'b0, 0, 1'b1, 1'b1, 1'b0);
    chk("r036_q3", 32'(q8), 32'h3);
    cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
    chk("r036_fix", 32'(q8), 32'h1);
    chk("r036_err", 32'(err8), 32'h1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        load = 1'($urandom_range(0, 1));
        en   = 1'($urandom_range(0, 1));
        mid_reset();
      end else begin
        cyc(($urandom_range(0, 7) == 0),
            int'($urandom_range(0, 255)),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 9) == 0) ? ~mode : mode,
            1'($urandom_range(0, 1)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
